exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_exec_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Four-state instruction sequencer: accept, operand read, execute, write-back.
// MUL is a 16-step shift-add when MUL_EN is set, otherwise it behaves as NOP.
module exec_ctrl #(
    parameter int MUL_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [1:0]  r_add1,
    output logic [1:0]  r_add2,
    input  logic [15:0] r_data1,
    input  logic [15:0] r_data2,
    output logic [1:0]  w_add,
    output logic        w_flag,
    output logic [15:0] w_data,
    output logic        done,
    output logic        flag_z,
    output logic        flag_c
);

    // state | meaning
    // IDLE  | waiting for instr_valid; instr_ready high
    // READ  | register-file addresses driven, operands latched at the edge
    // EXEC  | one cycle for ALU ops, 16 cycles for MUL
    // WB    | write strobe and done pulse; flags update at the exit edge
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] acc;
    logic [3:0]  step;
    logic        carry_q;

    logic [2:0]  op;
    logic [1:0]  rd;
    logic [7:0]  imm8;
    logic        is_mul;
    logic        is_nop;
    logic [16:0] sum17;
    logic [15:0] alu_res;
    logic        alu_c;
    logic [15:0] mul_addend;

    assign op     = instr_q[15:13];
    assign rd     = instr_q[12:11];
    assign imm8   = instr_q[7:0];
    assign r_add1 = instr_q[10:9];
    assign r_add2 = instr_q[8:7];
    assign is_mul = (MUL_EN != 0) && (op == OP_MUL);
    assign is_nop = (op == OP_NOP) || ((MUL_EN == 0) && (op == OP_MUL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        w_flag      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                if (!is_mul || (step == 4'd15)) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                done      = 1'b1;
                w_flag    = !is_nop;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sum17   = {1'b0, op_a} + {1'b0, op_b};
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum17[15:0];
                alu_c   = sum17[16];
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_LDI:  alu_res = {8'h00, imm8};
            default: alu_res = 16'h0000;
        endcase
    end

    // Partial product for the current multiplier bit; bits shifted past 15 drop out.
    assign mul_addend = op_b[step] ? (op_a << step) : 16'h0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 16'h0000;
            op_a    <= 16'h0000;
            op_b    <= 16'h0000;
            acc     <= 16'h0000;
            step    <= 4'd0;
            carry_q <= 1'b0;
            w_add   <= 2'd0;
            w_data  <= 16'h0000;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                READ: begin
                    op_a <= r_data1;
                    op_b <= r_data2;
                    acc  <= 16'h0000;
                    step <= 4'd0;
                end
                EXEC: begin
                    if (is_mul) begin
                        acc  <= acc + mul_addend;
                        step <= step + 4'd1;
                        if (step == 4'd15) begin
                            w_add  <= rd;
                            w_data <= acc + mul_addend;
                        end
                    end else begin
                        carry_q <= alu_c;
                        w_add   <= rd;
                        w_data  <= alu_res;
                    end
                end
                WB: begin
                    if (!is_nop) begin
                        flag_z <= (w_data == 16'h0000);
                    end
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        flag_c <= carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: owns the register file, runs directed and random
// instructions and compares against an arithmetic reference model.
module tb_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  r_add1, r_add2;
    logic [15:0] r_data1, r_data2;
    logic [1:0]  w_add;
    logic        w_flag;
    logic [15:0] w_data;
    logic        done;
    logic        flag_z, flag_c;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rf  [4];
    logic [15:0] mdl [4];
    logic        mdl_z = 1'b0;
    logic        mdl_c = 1'b0;

    always #5 clk = ~clk;

    exec_ctrl #(.MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .r_add1(r_add1), .r_add2(r_add2),
        .r_data1(r_data1), .r_data2(r_data2), .w_add(w_add), .w_flag(w_flag),
        .w_data(w_data), .done(done), .flag_z(flag_z), .flag_c(flag_c)
    );

    assign r_data1 = rf[r_add1];
    assign r_data2 = rf[r_add2];

    always @(posedge clk) begin
        if (w_flag) rf[w_add] <= w_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 7'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'd5, rd, 3'b000, imm};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after write-back.
    task automatic exec(input logic [15:0] ins, input bit noise);
        logic [2:0]  op;
        logic [15:0] a, b, res;
        logic [31:0] prod;
        logic        cy;
        bit          wr;
        int          lat, c;
        op  = ins[15:13];
        a   = mdl[ins[10:9]];
        b   = mdl[ins[8:7]];
        res = 16'h0;
        cy  = 1'b0;
        case (op)
            3'd0: {cy, res} = {1'b0, a} + {1'b0, b};
            3'd1: begin res = a - b; cy = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = {8'h00, ins[7:0]};
            3'd6: begin prod = a * b; res = prod[15:0]; end
            default: res = 16'h0;
        endcase
        wr  = (op != 3'd7);
        lat = (op == 3'd6) ? 18 : 3;

        chk("ready_idle", instr_ready, 1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (done) break;
            chk("ready_busy", instr_ready, 0);
            chk("wflag_busy", w_flag, 0);
            if (noise) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr = 16'($urandom);
            end
        end
        instr_valid = 1'b0;
        chk("latency", c, lat);
        chk("done", done, 1);
        chk("w_flag", w_flag, wr);
        if (wr) begin
            chk("w_add", w_add, ins[12:11]);
            chk("w_data", w_data, res);
        end
        @(negedge clk);
        if (wr) begin
            mdl[ins[12:11]] = res;
            mdl_z = (res == 16'h0);
            if (op <= 3'd1) mdl_c = cy;
            chk("w_data_hold", w_data, res);
            chk("rf_write", rf[ins[12:11]], res);
        end
        chk("done_pulse", done, 0);
        chk("wflag_pulse", w_flag, 0);
        chk("flag_z", flag_z, mdl_z);
        chk("flag_c", flag_c, mdl_c);
        chk("ready_after", instr_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_radd"}, {r_add1, r_add2}, 0);
        chk({tag, "_wadd"}, w_add, 0);
        chk({tag, "_wdata"}, w_data, 0);
        chk({tag, "_wflag"}, w_flag, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_flags"}, {flag_z, flag_c}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        instr = 16'h0;
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) exec(ldi(2'(i), 8'(8'h10 + i)), 1'b0);

        exec(ldi(2'd2, 8'hA5), 1'b0);
        chk("ldi_a5", rf[2], 16'h00A5);
        chk("ldi_z", flag_z, 0);

        // Build R0 = 0xFFFF via 0 - 1
        exec(ldi(2'd2, 8'h00), 1'b0);
        exec(ldi(2'd3, 8'h01), 1'b0);
        exec(enc(3'd1, 2'd0, 2'd2, 2'd3), 1'b0);
        chk("sub_ffff", rf[0], 16'hFFFF);
        exec(ldi(2'd1, 8'h01), 1'b0);
        exec(enc(3'd0, 2'd3, 2'd0, 2'd1), 1'b0);
        chk("add_wrap", rf[3], 16'h0000);
        chk("add_wrap_z", flag_z, 1);
        chk("add_wrap_c", flag_c, 1);

        exec(ldi(2'd1, 8'h03), 1'b0);
        exec(ldi(2'd2, 8'h05), 1'b0);
        exec(enc(3'd1, 2'd1, 2'd1, 2'd2), 1'b0);
        chk("sub_borrow", rf[1], 16'hFFFE);
        chk("sub_borrow_c", flag_c, 1);
        chk("sub_borrow_z", flag_z, 0);

        // R0 = 0xFF + 0x24 = 0x0123, R1 = 0x10
        exec(ldi(2'd2, 8'hFF), 1'b0);
        exec(ldi(2'd3, 8'h24), 1'b0);
        exec(enc(3'd0, 2'd0, 2'd2, 2'd3), 1'b0);
        exec(ldi(2'd1, 8'h10), 1'b0);
        exec(enc(3'd6, 2'd2, 2'd0, 2'd1), 1'b1);
        chk("mul_1230", rf[2], 16'h1230);

        // Back-to-back with instr_valid held high
        instr = ldi(2'd0, 8'h07);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr = enc(3'd0, 2'd1, 2'd0, 2'd0);
        n = 1;
        while (n < 10 && !instr_ready) begin
            if (done) chk("b2b_ldi", w_data, 16'h0007);
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", n, 4);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        n = 0;
        while (n < 10 && !done) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat", n, 3);
        chk("b2b_add", w_data, 16'h000E);
        @(negedge clk);
        mdl[0] = 16'h0007;
        mdl[1] = 16'h000E;
        mdl_z = 1'b0;
        mdl_c = 1'b0;

        // Reset in the middle of a MUL
        instr = enc(3'd6, 2'd3, 2'd1, 2'd1);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mulrst_wflag", w_flag, 0);
        end
        reset = 1'b1;
        #1;
        chk_reset_outputs("mulrst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("postrst_quiet", {w_flag, done}, 0);
            @(negedge clk);
        end
        chk("postrst_rf", rf[3], mdl[3]);
        mdl_z = 1'b0;
        mdl_c = 1'b0;

        for (int i = 0; i < 40; i++) begin
            exec(16'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
